store_queue: RTL
================

# store_queue

In-order, multi-entry store queue on the memory-write side of the load/store path. It accepts resolved stores from the ACU, holds them speculatively until the ROB retires them, then drains committed stores to data memory one per cycle. It drives `pending_stores` so the load buffer holds loads while any older store is still queued.

## Interface

Parameters:
- `SQ_DEPTH`, default 4: number of entries; power of two, ≥ 2.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `sq_packet_in`  in  SQ_PACKET: `{valid, address[XLEN], data[XLEN], rob_tag[ROB_TAG_LEN], mem_size[3]}` from ACU.
- `alloc_enable`  in  1: allocation strobe from ACU.
- `commit_valid`  in  1: ROB is retiring a store this cycle.
- `commit_rob_tag`  in  ROB_TAG_LEN: tag of the retiring store.
- `rollback`  in  1: squash all uncommitted stores (mispredict/exception).
- `mem_stall`  in  1: memory/hazard unit blocks the write this cycle.
- `full`  out  1: no free entry; to ACU.
- `pending_stores`  out  1: queue non-empty; to load buffer.
- `write_mem`  out  1: committed store presented to memory.
- `store_address`  out  XLEN: head entry address.
- `store_data`  out  XLEN: head entry data.
- `store_size`  out  3: head entry `mem_size`.

## Operation

- Entry states: EMPTY, WAITING (allocated, not retired), COMMITTED (retired, awaiting memory).
- Three pointers, each `$clog2(SQ_DEPTH)` bits, wrapping modulo `SQ_DEPTH`: `head` (oldest), `commit_ptr` (oldest WAITING), `tail` (next free). Also an occupancy `count`, `$clog2(SQ_DEPTH)+1` bits.
- Order is head ≤ commit_ptr ≤ tail in program order. Entries [head, commit_ptr) are COMMITTED; entries [commit_ptr, tail) are WAITING.
- Allocate: when `alloc_enable & sq_packet_in.valid & ~full`, write the packet at `tail` as WAITING and advance `tail`. The request is dropped silently when `full`.
- Commit: when `commit_valid`, the entry at `commit_ptr` is WAITING, and its `rob_tag == commit_rob_tag`, mark it COMMITTED and advance `commit_ptr`. Otherwise ignore the request; no state changes.
- Drain: `write_mem` = head entry is COMMITTED. When `write_mem & ~mem_stall`, free the head entry (EMPTY) and advance `head`. At most one drain per cycle.
- Rollback: all WAITING entries become EMPTY, `tail <= commit_ptr`, and `count` drops by the WAITING count. COMMITTED entries are untouched and keep draining.
- `full` = (`count == SQ_DEPTH`), combinational from registered state.
- `pending_stores` = (`count != 0`). This is conservative: any queued store blocks loads.
- `store_address`, `store_data`, `store_size` show the head entry while `write_mem` is 1, and are 0 otherwise.

## Timing

- Reset: all entries EMPTY, all pointers and `count` 0. Outputs: `full` 0, `pending_stores` 0, `write_mem` 0, `store_address`/`store_data`/`store_size` 0. Reset overrides every other input in the same cycle. Reset mid-drain discards all entries, including COMMITTED ones.
- Allocate at edge N: entry exists from N+1, and `pending_stores` is 1 from N+1.
- Commit at edge N: entry COMMITTED from N+1. `write_mem` rises at N+1 at the earliest, and only if the entry is at head.
- Drain at edge N: head advances at N+1. Back-to-back COMMITTED entries drain one per cycle with no bubble.
- `mem_stall` high: the head entry and outputs hold steady; `write_mem` stays 1.
- Simultaneous events within one edge:
  - Alloc + drain: both happen; `count` unchanged. While `full`, the alloc is still rejected even if a drain frees a slot that cycle.
  - Alloc + commit: commit evaluates only entries that existed before the edge.
  - Commit + rollback: commit applies first; the newly committed entry survives and the rest of WAITING is squashed.
  - Rollback + alloc: rollback wins; the allocation is discarded.
  - Rollback + drain: the drain proceeds.
- Wrap-around: pointers wrap from `SQ_DEPTH-1` to 0. Full and empty are distinguished by `count` only.

## Test plan

- Reset then idle: all outputs 0. Allocate one store (addr 0x100, data 0xDEAD, tag 3) → `pending_stores` 1 next cycle and `write_mem` 0. Commit tag 3 → `write_mem` 1 with addr 0x100 one cycle later. Drain → `pending_stores` 0.
- Fill 4 entries → `full` 1 and a 5th alloc is dropped. Commit all 4 and hold `mem_stall` for 3 cycles → outputs stable. Release → 4 writes on 4 consecutive cycles in allocation order.
- Commit with wrong tag (head tag 5, commit tag 6) → ignored and state unchanged. Then commit tag 5 → accepted.
- 2 COMMITTED + 2 WAITING, assert `rollback` together with commit of the first WAITING → 3 entries remain and 1 is squashed. `tail` equals the new `commit_ptr`, and the next alloc lands directly after it.
- Steady alloc/commit/drain across 10 stores with `SQ_DEPTH`=4 → pointer wrap exercised, memory writes in program order, `count` never above 4.
- Assert `reset` while 3 entries are COMMITTED and `write_mem` is 1 → all outputs 0 next cycle and no further writes.

Source files
------------

// File: rtl/store_queue_if.sv
// Store queue port bundle: ACU allocation, ROB commit/rollback, memory write.
// master drives requests and sees status; slave is the queue itself.
interface store_queue_if #(
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
);
    typedef struct packed {
        logic                   valid;
        logic [XLEN-1:0]        address;
        logic [XLEN-1:0]        data;
        logic [ROB_TAG_LEN-1:0] rob_tag;
        logic [2:0]             mem_size;
    } sq_packet_t;

    sq_packet_t             sq_packet_in;
    logic                   alloc_enable;
    logic                   commit_valid;
    logic [ROB_TAG_LEN-1:0] commit_rob_tag;
    logic                   rollback;
    logic                   mem_stall;
    logic                   full;
    logic                   pending_stores;
    logic                   write_mem;
    logic [XLEN-1:0]        store_address;
    logic [XLEN-1:0]        store_data;
    logic [2:0]             store_size;

    modport master (
        output sq_packet_in, alloc_enable, commit_valid,
        output commit_rob_tag, rollback, mem_stall,
        input  full, pending_stores, write_mem,
        input  store_address, store_data, store_size
    );

    modport slave (
        input  sq_packet_in, alloc_enable, commit_valid,
        input  commit_rob_tag, rollback, mem_stall,
        output full, pending_stores, write_mem,
        output store_address, store_data, store_size
    );
endinterface

// File: rtl/store_queue.sv
// In-order store queue: holds stores until retired, drains one per cycle.
// Ports: clock, reset (sync, active-high), sq (store_queue_if.slave).
module store_queue #(
    parameter int SQ_DEPTH    = 4,
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
) (
    input  logic          clock,
    input  logic          reset,
    store_queue_if.slave  sq
);
    localparam int PW = $clog2(SQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        E_EMPTY,
        E_WAIT,
        E_COMMIT
    } ent_e;

    ent_e                   r_state [SQ_DEPTH];
    ent_e                   w_state_nxt [SQ_DEPTH];
    logic [XLEN-1:0]        r_addr [SQ_DEPTH];
    logic [XLEN-1:0]        r_data [SQ_DEPTH];
    logic [ROB_TAG_LEN-1:0] r_tag [SQ_DEPTH];
    logic [2:0]             r_size [SQ_DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_cptr;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_write;
    logic          w_drain;
    logic          w_alloc;
    logic          w_commit;
    logic [PW-1:0] w_cptr_nxt;
    logic [CW-1:0] w_nwait;
    logic [CW-1:0] w_squash;
    logic [CW-1:0] w_count_nxt;

    assign w_full  = (r_count == CW'(SQ_DEPTH));
    assign w_write = (r_state[r_head] == E_COMMIT);
    assign w_drain = w_write & ~sq.mem_stall;

    // Rollback discards a same-cycle allocation.
    assign w_alloc = sq.alloc_enable & sq.sq_packet_in.valid
                   & ~w_full & ~sq.rollback;

    assign w_commit = sq.commit_valid
                    & (r_state[r_cptr] == E_WAIT)
                    & (r_tag[r_cptr] == sq.commit_rob_tag);

    assign w_cptr_nxt = r_cptr + PW'(w_commit);

    always_comb begin
        w_nwait = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (r_state[i] == E_WAIT) begin
                w_nwait = w_nwait + CW'(1);
            end
        end
        // A commit in the rollback cycle saves that one entry.
        w_squash = '0;
        if (sq.rollback) begin
            w_squash = w_nwait - CW'(w_commit);
        end
        w_count_nxt = r_count + CW'(w_alloc) - CW'(w_drain) - w_squash;

        for (int i = 0; i < SQ_DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
            if (sq.rollback && r_state[i] == E_WAIT) begin
                w_state_nxt[i] = E_EMPTY;
            end
            if (w_commit && PW'(i) == r_cptr) begin
                w_state_nxt[i] = E_COMMIT;
            end
            if (w_drain && PW'(i) == r_head) begin
                w_state_nxt[i] = E_EMPTY;
            end
            if (w_alloc && PW'(i) == r_tail) begin
                w_state_nxt[i] = E_WAIT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                r_state[i] <= E_EMPTY;
            end
            r_head  <= '0;
            r_cptr  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            r_head  <= r_head + PW'(w_drain);
            r_cptr  <= w_cptr_nxt;
            r_tail  <= sq.rollback ? w_cptr_nxt
                                   : r_tail + PW'(w_alloc);
            r_count <= w_count_nxt;
        end
    end

    // Payload needs no reset: it is only visible behind a COMMITTED state.
    always_ff @(posedge clock) begin
        if (w_alloc) begin
            r_addr[r_tail] <= sq.sq_packet_in.address;
            r_data[r_tail] <= sq.sq_packet_in.data;
            r_tag[r_tail]  <= sq.sq_packet_in.rob_tag;
            r_size[r_tail] <= sq.sq_packet_in.mem_size;
        end
    end

    assign sq.full           = w_full;
    assign sq.pending_stores = (r_count != '0);
    assign sq.write_mem      = w_write;
    assign sq.store_address  = w_write ? r_addr[r_head] : '0;
    assign sq.store_data     = w_write ? r_data[r_head] : '0;
    assign sq.store_size     = w_write ? r_size[r_head] : '0;
endmodule
